// File: rtl/io_timer8_pkg.sv
// io_timer8 shared definitions: register offsets, clock-select codes
// and flag/mask bit positions.
package io_timer8_pkg;

    localparam logic [2:0] OFF_TCCR  = 3'd0;
    localparam logic [2:0] OFF_TCNT  = 3'd1;
    localparam logic [2:0] OFF_OCR   = 3'd2;
    localparam logic [2:0] OFF_TIFR  = 3'd3;
    localparam logic [2:0] OFF_TIMSK = 3'd4;

    localparam logic [7:0] NUM_REGS  = 8'd5;

    localparam logic [2:0] CS_STOP    = 3'd0;
    localparam logic [2:0] CS_DIV1    = 3'd1;
    localparam logic [2:0] CS_DIV8    = 3'd2;
    localparam logic [2:0] CS_DIV64   = 3'd3;
    localparam logic [2:0] CS_DIV256  = 3'd4;
    localparam logic [2:0] CS_DIV1024 = 3'd5;

    localparam int TOV_BIT = 0;
    localparam int OCF_BIT = 1;
    localparam int CTC_BIT = 3;

    function automatic logic cs_running(input logic [2:0] cs);
        return (cs >= CS_DIV1) && (cs <= CS_DIV1024);
    endfunction

endpackage

// File: rtl/io_timer8_prescaler.sv
// timer_prescaler: 10-bit free-running divider producing the counter
// tick for the selected clock source.
module timer_prescaler
    import io_timer8_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] cs,
    output logic       tick
);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;

    // Next divider value: cleared on TCCR write, frozen while stopped
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 10'h000;
        end else if (cs_running(cs)) begin
            cnt_d = cnt_q + 10'h001;
        end
    end

    // Divider state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 10'h000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick when the low divider bits for the selected ratio are all ones
    always_comb begin
        case (cs)
            CS_DIV1:    tick = 1'b1;
            CS_DIV8:    tick = &cnt_q[2:0];
            CS_DIV64:   tick = &cnt_q[5:0];
            CS_DIV256:  tick = &cnt_q[7:0];
            CS_DIV1024: tick = &cnt_q[9:0];
            default:    tick = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_timer8.sv
// io_timer8: 8-bit timer/counter on the I/O register bus.
// Optional PWM output enabled by defining IO_TIMER8_PWM_EN.
module io_timer8
    import io_timer8_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] io_addr,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       irq,
    output logic       pwm_out
);

    logic [3:0] tccr_q, tccr_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] ocr_q, ocr_d;
    logic [1:0] tifr_q, tifr_d;
    logic [1:0] timsk_q, timsk_d;

    logic [7:0] off;
    logic       in_range;
    logic       we_hit;
    logic       we_tccr, we_tcnt, we_ocr, we_tifr, we_timsk;
    logic       tick;
    logic       match;
    logic       wrap;
    logic [1:0] flag_set;
    logic [1:0] flag_clr;

    assign off      = io_addr - BASE_ADDR;
    assign in_range = (off < NUM_REGS);
    assign we_hit   = io_we & in_range;
    assign we_tccr  = we_hit & (off[2:0] == OFF_TCCR);
    assign we_tcnt  = we_hit & (off[2:0] == OFF_TCNT);
    assign we_ocr   = we_hit & (off[2:0] == OFF_OCR);
    assign we_tifr  = we_hit & (off[2:0] == OFF_TIFR);
    assign we_timsk = we_hit & (off[2:0] == OFF_TIMSK);

    timer_prescaler u_presc (
        .clock (clock),
        .reset (reset),
        .clear (we_tccr),
        .cs    (tccr_q[2:0]),
        .tick  (tick)
    );

    // Counter, compare and flag next-state; a CPU TCNT write suppresses the tick
    always_comb begin
        tccr_d   = we_tccr  ? io_wdata[3:0] : tccr_q;
        ocr_d    = we_ocr   ? io_wdata      : ocr_q;
        timsk_d  = we_timsk ? io_wdata[1:0] : timsk_q;
        tcnt_d   = tcnt_q;
        match    = (tcnt_q == ocr_q);
        wrap     = 1'b0;
        flag_set = 2'b00;
        if (we_tcnt) begin
            tcnt_d = io_wdata;
        end else if (tick) begin
            flag_set[OCF_BIT] = match;
            if (match && tccr_q[CTC_BIT]) begin
                tcnt_d = 8'h00;
            end else begin
                tcnt_d = tcnt_q + 8'h01;
                wrap   = (tcnt_q == 8'hFF);
            end
            flag_set[TOV_BIT] = wrap;
        end
        flag_clr = we_tifr ? io_wdata[1:0] : 2'b00;
        tifr_d   = (tifr_q & ~flag_clr) | flag_set;
    end

    // Register file
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tccr_q  <= 4'h0;
            tcnt_q  <= 8'h00;
            ocr_q   <= 8'h00;
            tifr_q  <= 2'b00;
            timsk_q <= 2'b00;
        end else begin
            tccr_q  <= tccr_d;
            tcnt_q  <= tcnt_d;
            ocr_q   <= ocr_d;
            tifr_q  <= tifr_d;
            timsk_q <= timsk_d;
        end
    end

    // Read mux, zero outside an in-range read so it can be OR-combined
    always_comb begin
        io_rdata = 8'h00;
        if (io_re && in_range) begin
            case (off[2:0])
                OFF_TCCR:  io_rdata = {4'h0, tccr_q};
                OFF_TCNT:  io_rdata = tcnt_q;
                OFF_OCR:   io_rdata = ocr_q;
                OFF_TIFR:  io_rdata = {6'h00, tifr_q};
                OFF_TIMSK: io_rdata = {6'h00, timsk_q};
                default:   io_rdata = 8'h00;
            endcase
        end
    end

    assign irq = |(tifr_q & timsk_q);

`ifdef IO_TIMER8_PWM_EN
    logic pwm_q;

    // PWM level: high while the counter is below the compare value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (tcnt_q < ocr_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_io_timer8.sv
// Directed self-checking bench for io_timer8.
module tb_io_timer8;

    localparam logic [7:0] A_TCCR  = 8'h30;
    localparam logic [7:0] A_TCNT  = 8'h31;
    localparam logic [7:0] A_OCR   = 8'h32;
    localparam logic [7:0] A_TIFR  = 8'h33;
    localparam logic [7:0] A_TIMSK = 8'h34;

    logic       clock;
    logic       reset;
    logic [7:0] io_addr;
    logic       io_re;
    logic       io_we;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       irq;
    logic       pwm_out;

    int tests;
    int fails;
    int hi_cnt;
    int pwm_exp;

    io_timer8 #(.BASE_ADDR(8'h30)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_addr  (io_addr),
        .io_re    (io_re),
        .io_we    (io_we),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .irq      (irq),
        .pwm_out  (pwm_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        step(1);
        io_we    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
        io_addr = a;
        io_re   = 1'b1;
        #1;
        chk(tag, io_rdata, exp);
        step(1);
        io_re   = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        io_addr  = 8'h00;
        io_re    = 1'b0;
        io_we    = 1'b0;
        io_wdata = 8'h00;
        step(2);
        reset = 1'b0;
        step(1);

        chk("rst_irq", {7'h0, irq}, 8'h00);
        chk("rst_pwm", {7'h0, pwm_out}, 8'h00);
        rd(A_TCCR,  8'h00, "rst_tccr");
        rd(A_TCNT,  8'h00, "rst_tcnt");
        rd(A_OCR,   8'h00, "rst_ocr");
        rd(A_TIFR,  8'h00, "rst_tifr");
        rd(A_TIMSK, 8'h00, "rst_timsk");

        wr(A_TCCR, 8'hFF);
        rd(A_TCCR, 8'h0F, "tccr_mask");
        wr(A_TCCR, 8'h00);

        // compare flag and irq, clk/1
        wr(A_OCR,   8'h05);
        wr(A_TIMSK, 8'h02);
        wr(A_TCCR,  8'h01);
        rd(A_TCNT, 8'h00, "cmp_cnt0");
        rd(A_TCNT, 8'h01, "cmp_cnt1");
        rd(A_TCNT, 8'h02, "cmp_cnt2");
        rd(A_TCNT, 8'h03, "cmp_cnt3");
        rd(A_TCNT, 8'h04, "cmp_cnt4");
        chk("cmp_irq_lo", {7'h0, irq}, 8'h00);
        rd(A_TCNT, 8'h05, "cmp_cnt5");
        chk("cmp_irq_hi", {7'h0, irq}, 8'h01);
        rd(A_TIFR, 8'h02, "cmp_tifr");
        wr(A_TIFR, 8'h02);
        chk("cmp_irq_clr", {7'h0, irq}, 8'h00);
        wr(A_TCCR, 8'h00);
        rd(A_TCNT, 8'h09, "cmp_stop");
        rd(A_TCNT, 8'h09, "cmp_hold");

        // CTC
        wr(A_TIMSK, 8'h00);
        wr(A_TCNT,  8'h00);
        wr(A_OCR,   8'h03);
        wr(A_TCCR,  8'h09);
        rd(A_TCNT, 8'h00, "ctc_0");
        rd(A_TCNT, 8'h01, "ctc_1");
        rd(A_TCNT, 8'h02, "ctc_2");
        rd(A_TCNT, 8'h03, "ctc_3");
        rd(A_TCNT, 8'h00, "ctc_wrap0");
        rd(A_TCNT, 8'h01, "ctc_wrap1");
        rd(A_TIFR, 8'h02, "ctc_no_tov");
        wr(A_TCCR, 8'h00);
        wr(A_TIFR, 8'h03);
        rd(A_TIFR, 8'h00, "tifr_clr");

        // overflow, clk/8
        wr(A_TCNT, 8'hFE);
        wr(A_TCCR, 8'h02);
        step(7);
        rd(A_TCNT, 8'hFE, "ovf_pre");
        rd(A_TCNT, 8'hFF, "ovf_ff");
        step(6);
        rd(A_TCNT, 8'hFF, "ovf_ff_end");
        rd(A_TIFR, 8'h01, "ovf_tov");
        rd(A_TCNT, 8'h00, "ovf_00");
        wr(A_TCCR, 8'h00);
        wr(A_TIFR, 8'h03);

        // TCNT write beats tick
        wr(A_TCCR, 8'h01);
        wr(A_TCNT, 8'h40);
        rd(A_TCNT, 8'h40, "col_tcnt");
        rd(A_TCNT, 8'h41, "col_tcnt_inc");
        wr(A_TCCR, 8'h00);
        wr(A_TIFR, 8'h03);

        // OCF set beats write-1-clear
        wr(A_TCNT, 8'h44);
        wr(A_OCR,  8'h45);
        wr(A_TCCR, 8'h01);
        step(1);
        wr(A_TIFR, 8'h02);
        rd(A_TIFR, 8'h02, "col_ocf");
        wr(A_TIFR, 8'h02);
        rd(A_TIFR, 8'h00, "ocf_clr");
        wr(A_TCCR, 8'h00);

        // simultaneous read and write
        io_addr  = A_OCR;
        io_wdata = 8'h77;
        io_re    = 1'b1;
        io_we    = 1'b1;
        #1;
        chk("rw_old", io_rdata, 8'h45);
        step(1);
        io_re = 1'b0;
        io_we = 1'b0;
        rd(A_OCR, 8'h77, "rw_new");

        // out of range and idle bus
        wr(8'h35, 8'hFF);
        rd(8'h35, 8'h00, "oor_hi");
        rd(8'h2F, 8'h00, "oor_lo");
        rd(A_TIMSK, 8'h00, "oor_nowrite");
        io_addr = A_OCR;
        #1;
        chk("no_re", io_rdata, 8'h00);

        // PWM duty over one full counter period
        wr(A_OCR,  8'h80);
        wr(A_TCNT, 8'h00);
        wr(A_TCCR, 8'h01);
        step(3);
        hi_cnt = 0;
        repeat (256) begin
            @(negedge clock);
            if (pwm_out) hi_cnt++;
        end
`ifdef IO_TIMER8_PWM_EN
        pwm_exp = 128;
`else
        pwm_exp = 0;
`endif
        chk("pwm_duty", hi_cnt[7:0] | {7'h0, hi_cnt[8]}, pwm_exp[7:0] | {7'h0, pwm_exp[8]});
        step(1);

        // asynchronous reset mid-count
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        chk("arst_pwm", {7'h0, pwm_out}, 8'h00);
        step(1);
        rd(A_TCNT, 8'h00, "arst_tcnt");
        rd(A_TCNT, 8'h00, "arst_hold");
        rd(A_TCCR, 8'h00, "arst_tccr");
        rd(A_OCR,  8'h00, "arst_ocr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
